// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg
// Shared definitions for the dot-product MAC sequencer:
//   state_t            - 2-bit FSM state encoding (IDLE, ISSUE, WAIT, DONE)
//   mac_total_latency  - cycles from MAC inputs presented to mac_z valid
package mac_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Multiplier stages, one register between multiplier and adder, adder stages.
    function automatic int mac_total_latency(input int mult_lat, input int add_lat);
        return mult_lat + 1 + add_lat;
    endfunction

endpackage

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
// Sequences a dot product of len signed operand pairs through an externally
// instantiated pipelined MAC (mac_z = mac_a * mac_b + mac_c, latency L).
// One element is in flight at a time; the accumulator is fed back as mac_c.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, len, busy    command: start a dot product of len elements
//   in_valid, in_ready  operand handshake for a_i / b_i
//   mac_a, mac_b, mac_c registered MAC operands (one-cycle pulse per element)
//   mac_z               MAC result
//   res_valid, res_ready, res_data   result handshake
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int A_width       = 8,
    parameter int B_width       = 8,
    parameter int SUM_width     = 16,
    parameter int MULT_LATENCY  = 1,
    parameter int ADDER_LATENCY = 1,
    parameter int LEN_width     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_width-1:0] len,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_width-1:0]   a_i,
    input  logic [B_width-1:0]   b_i,
    output logic [A_width-1:0]   mac_a,
    output logic [B_width-1:0]   mac_b,
    output logic [SUM_width-1:0] mac_c,
    input  logic [SUM_width-1:0] mac_z,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SUM_width-1:0] res_data
);

    localparam int L     = mac_total_latency(MULT_LATENCY, ADDER_LATENCY);
    localparam int CNT_W = $clog2(L + 1) + 1;

    state_t                 state_r, state_nx_s;
    logic [LEN_width-1:0]   remaining_r, remaining_nx_s;
    logic [SUM_width-1:0]   acc_r, acc_nx_s;
    logic [CNT_W-1:0]       cnt_r, cnt_nx_s;
    logic                   handshake_s;

    logic                   busy_r;
    logic                   in_ready_r;
    logic                   res_valid_r;
    logic [SUM_width-1:0]   res_data_r;
    logic [A_width-1:0]     mac_a_r;
    logic [B_width-1:0]     mac_b_r;
    logic [SUM_width-1:0]   mac_c_r;

    // Next-state, accumulator, element counter and wait counter decode.
    always_comb begin
        state_nx_s     = state_r;
        remaining_nx_s = remaining_r;
        acc_nx_s       = acc_r;
        cnt_nx_s       = cnt_r;
        handshake_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    acc_nx_s = {SUM_width{1'b0}};
                    if (len != {LEN_width{1'b0}}) begin
                        state_nx_s     = ST_ISSUE;
                        remaining_nx_s = len;
                    end else begin
                        state_nx_s     = ST_DONE;
                        remaining_nx_s = {LEN_width{1'b0}};
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (in_valid) begin
                    handshake_s    = 1'b1;
                    remaining_nx_s = remaining_r - {{(LEN_width-1){1'b0}}, 1'b1};
                    cnt_nx_s       = {CNT_W{1'b0}};
                    state_nx_s     = ST_WAIT;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // WAIT spans L+1 cycles: one for the operand register, L for the MAC.
                if (cnt_r == CNT_W'(L)) begin
                    acc_nx_s = mac_z;
                    cnt_nx_s = {CNT_W{1'b0}};
                    if (remaining_r != {LEN_width{1'b0}}) begin
                        state_nx_s = ST_ISSUE;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    cnt_nx_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, element count, accumulator and wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            remaining_r <= {LEN_width{1'b0}};
            acc_r       <= {SUM_width{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            remaining_r <= remaining_nx_s;
            acc_r       <= acc_nx_s;
            cnt_r       <= cnt_nx_s;
        end
    end

    // Registered outputs, decoded from the next state so they align with state_r.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= {SUM_width{1'b0}};
            mac_a_r     <= {A_width{1'b0}};
            mac_b_r     <= {B_width{1'b0}};
            mac_c_r     <= {SUM_width{1'b0}};
        end else begin
            busy_r      <= (state_nx_s != ST_IDLE);
            in_ready_r  <= (state_nx_s == ST_ISSUE);
            res_valid_r <= (state_nx_s == ST_DONE);
            res_data_r  <= (state_nx_s == ST_DONE) ? acc_nx_s : {SUM_width{1'b0}};
            // MAC operands are a single-cycle pulse; zero keeps the MAC input quiet.
            mac_a_r     <= handshake_s ? a_i   : {A_width{1'b0}};
            mac_b_r     <= handshake_s ? b_i   : {B_width{1'b0}};
            mac_c_r     <= handshake_s ? acc_r : {SUM_width{1'b0}};
        end
    end

    assign busy      = busy_r;
    assign in_ready  = in_ready_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign mac_a     = mac_a_r;
    assign mac_b     = mac_b_r;
    assign mac_c     = mac_c_r;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl
// Drives mac_seq_ctrl attached to a behavioural 3-cycle MAC model and checks
// dot-product results, handshake counts/spacing, reset and result holding.
module tb_mac_seq_ctrl;

    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         a_i;
    logic [7:0]         b_i;
    logic [7:0]         mac_a;
    logic [7:0]         mac_b;
    logic [15:0]        mac_c;
    logic [15:0]        mac_z;
    logic               res_valid;
    logic               res_ready;
    logic signed [15:0] res_data;

    int total;
    int bad;

    mac_seq_ctrl #(
        .A_width(8), .B_width(8), .SUM_width(16),
        .MULT_LATENCY(1), .ADDER_LATENCY(1), .LEN_width(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_i(a_i), .b_i(b_i),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_z(mac_z),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached MAC: z = a*b + c, valid 3 cycles after the inputs are presented.
    logic signed [15:0] mul_s;
    logic signed [15:0] sum_s;
    logic [15:0]        pipe_r [0:2];
    assign mul_s = $signed(mac_a) * $signed(mac_b);
    assign sum_s = mul_s + $signed(mac_c);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_r[0] <= 16'd0;
            pipe_r[1] <= 16'd0;
            pipe_r[2] <= 16'd0;
        end else begin
            pipe_r[0] <= sum_s;
            pipe_r[1] <= pipe_r[0];
            pipe_r[2] <= pipe_r[1];
        end
    end
    assign mac_z = pipe_r[2];

    typedef struct {
        int n;
        bit rnd;
        int off;
        int exp;
    } vec_t;

    vec_t tbl [0:7];
    int   op_a [0:25];
    int   op_b [0:25];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic begin_dot(input int n);
        @(negedge clk);
        start = 1'b1;
        len   = 8'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds operands from the current negedge until res_valid is seen.
    task automatic feed(input int n, input bit rnd, input int off,
                        output int got, output int hs, output int lat);
        int idx;
        int last;
        bit done;
        idx  = 0;
        last = -1;
        done = 1'b0;
        hs   = 0;
        got  = 0;
        lat  = -1;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (res_valid) begin
                got  = int'(res_data);
                lat  = cyc;
                done = 1'b1;
            end else begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                a_i = (idx < n) ? 8'(op_a[off + idx]) : 8'd99;
                b_i = (idx < n) ? 8'(op_b[off + idx]) : 8'd99;
                if (in_ready && in_valid) begin
                    if (last >= 0) begin
                        if (rnd) chk("issue_gap_min", int'(cyc - last >= 5), 1);
                        else     chk("issue_gap", cyc - last, 5);
                    end
                    last = cyc;
                    idx++;
                    hs++;
                end
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
        if (!done) chk("result_timeout", 0, 1);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_fall", int'(res_valid), 0);
        chk("busy_after_done", int'(busy), 0);
    endtask

    int got, hs, lat;
    int hold_ref;

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0;
        a_i = 8'd0; b_i = 8'd0; res_ready = 1'b0;

        op_a = '{2, 4, -1, 127, 127, 127, 127, 127, 1, -2, 3, -4, 5, -128,
                 -128, -128, -128, -128, 7, 8, 9, 10, 11, 5, 3, 2};
        op_b = '{3, 5, 7, 127, 127, 127, 127, 127, 10, 20, -30, 40, -50, -128,
                 127, 127, 127, 127, -1, -1, -1, -1, -1, -6, 3, 2};
        tbl[0] = '{n: 3, rnd: 1'b0, off: 0,  exp: 19};
        tbl[1] = '{n: 0, rnd: 1'b0, off: 0,  exp: 0};
        tbl[2] = '{n: 2, rnd: 1'b0, off: 3,  exp: 32258};
        tbl[3] = '{n: 3, rnd: 1'b0, off: 5,  exp: -17149};
        tbl[4] = '{n: 5, rnd: 1'b1, off: 8,  exp: -530};
        tbl[5] = '{n: 1, rnd: 1'b0, off: 13, exp: 16384};
        tbl[6] = '{n: 4, rnd: 1'b0, off: 14, exp: 512};
        tbl[7] = '{n: 5, rnd: 1'b1, off: 18, exp: -45};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_mac_c", int'(mac_c), 0);
        rst = 1'b1;

        // Table-driven dot products
        for (int v = 0; v < 8; v++) begin
            begin_dot(tbl[v].n);
            feed(tbl[v].n, tbl[v].rnd, tbl[v].off, got, hs, lat);
            chk($sformatf("v%0d_result", v), got, tbl[v].exp);
            chk($sformatf("v%0d_handshakes", v), hs, tbl[v].n);
            if (!tbl[v].rnd) chk($sformatf("v%0d_latency", v), lat, 5 * tbl[v].n);
            release_result();
        end

        // Result held while res_ready is low; start pulses ignored
        begin_dot(1);
        feed(1, 1'b0, 23, got, hs, lat);
        chk("hold_first", got, -30);
        for (int c = 0; c < 10; c++) begin
            start = ~start;
            len   = 8'd7;
            @(negedge clk);
            chk("hold_res_valid", int'(res_valid), 1);
            chk("hold_res_data", int'(res_data), -30);
            chk("hold_busy", int'(busy), 1);
        end
        start = 1'b0;

        // Start on the DONE->IDLE cycle is not taken; the next cycle is
        res_ready = 1'b1;
        start = 1'b1;
        len   = 8'd1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("restart_busy_low", int'(busy), 0);
        chk("restart_valid_low", int'(res_valid), 0);
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy_high", int'(busy), 1);
        chk("restart_in_ready", int'(in_ready), 1);
        feed(1, 1'b0, 25, got, hs, lat);
        chk("restart_result", got, 4);
        release_result();

        // Reset in WAIT of element 2 of a len=4 product
        begin_dot(4);
        hs = 0;
        for (int cyc = 0; cyc < 50 && hs < 2; cyc++) begin
            in_valid = 1'b1;
            a_i = 8'd1;
            b_i = 8'd1;
            if (in_ready) hs++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_rst_handshakes", hs, 2);
        @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        chk("mid_rst_res_valid", int'(res_valid), 0);
        chk("mid_rst_res_data", int'(res_data), 0);
        chk("mid_rst_mac_a", int'(mac_a), 0);
        chk("mid_rst_mac_b", int'(mac_b), 0);
        chk("mid_rst_mac_c", int'(mac_c), 0);
        @(negedge clk);
        rst = 1'b1;
        hold_ref = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid || busy) hold_ref++;
        end
        chk("post_rst_quiet", hold_ref, 0);
        op_a[24] = 3;
        op_b[24] = 3;
        begin_dot(1);
        feed(1, 1'b0, 24, got, hs, lat);
        chk("post_rst_result", got, 9);
        chk("post_rst_handshakes", hs, 1);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
